// File: rtl/timekeep_pkg.sv
// rtl/timekeep_pkg.sv - shared time-base widths, default stage packings and stage-select encoding
package timekeep_pkg;

  localparam int TK_STAGE_W    = 7;
  localparam int TK_NUM_STAGES = 4;

  // Stage 0 (hundredths) sits in the LSBs; a field of 0 means modulus 2^STAGE_W.
  localparam logic [27:0] WATCH_MODULI     = {7'd24, 7'd60, 7'd60, 7'd100};
  localparam logic [27:0] WATCH_INIT       = {7'd0, 7'd0, 7'd0, 7'd0};
  localparam logic [27:0] STOPWATCH_MODULI = {7'd100, 7'd60, 7'd60, 7'd100};
  localparam logic [27:0] STOPWATCH_INIT   = {7'd0, 7'd0, 7'd0, 7'd0};

  typedef enum logic [1:0] {
    SEL_HSEC = 2'd0,
    SEL_SEC  = 2'd1,
    SEL_MIN  = 2'd2,
    SEL_HOUR = 2'd3
  } stage_sel_e;

endpackage

// File: rtl/mod_stage.sv
// rtl/mod_stage.sv - one modulo-MOD counter stage with clear, saturating load, edit and step
module mod_stage #(
  parameter int STAGE_W  = 7,
  parameter int MOD      = 10,
  parameter int INIT_VAL = 0
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               load,
  input  logic [STAGE_W-1:0] load_val,
  input  logic               step,
  input  logic               dir,
  input  logic               edit_up,
  input  logic               edit_dn,
  output logic [STAGE_W-1:0] q,
  output logic               at_carry
);

  localparam logic [STAGE_W-1:0] LAST   = STAGE_W'(MOD - 1);
  localparam logic [STAGE_W-1:0] INIT_Q = STAGE_W'(INIT_VAL);

  logic [STAGE_W-1:0] inc;
  logic [STAGE_W-1:0] dec;

  assign inc      = (q == LAST) ? '0 : q + 1'b1;
  assign dec      = (q == '0) ? LAST : q - 1'b1;
  assign at_carry = dir ? (q == '0) : (q == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= INIT_Q;
    end else if (clear) begin
      q <= INIT_Q;
    end else if (load) begin
      q <= (load_val > LAST) ? LAST : load_val;
    end else if (edit_up) begin
      q <= inc;
    end else if (edit_dn) begin
      q <= dec;
    end else if (step) begin
      q <= dir ? dec : inc;
    end
  end

endmodule

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divide-by-DIV base tick generator with run/hold/restart
module tick_prescaler #(
  parameter int DIV = 10
)(
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
      tick  <= 1'b0;
    end else if (restart) begin
      phase <= '0;
      tick  <= 1'b0;
    end else if (run) begin
      if (phase == LAST) begin
        phase <= '0;
        tick  <= 1'b1;
      end else begin
        phase <= phase + 1'b1;
        tick  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/cascaded_time_counter.sv
// rtl/cascaded_time_counter.sv - N-stage cascaded modulo time base with prescaler, load, edit and one-shot expiry
module cascaded_time_counter
  import timekeep_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 100,
  parameter int NUM_STAGES = TK_NUM_STAGES,
  parameter int STAGE_W    = TK_STAGE_W,
  parameter logic [NUM_STAGES*STAGE_W-1:0] MODULI = WATCH_MODULI,
  parameter logic [NUM_STAGES*STAGE_W-1:0] INIT   = WATCH_INIT,
  localparam int SEL_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
)(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_run,
  input  logic                          i_clear,
  input  logic                          i_dir,
  input  logic                          i_oneshot,
  input  logic                          i_load,
  input  logic [NUM_STAGES*STAGE_W-1:0] i_load_val,
  input  logic [SEL_W-1:0]              i_edit_sel,
  input  logic                          i_edit_up,
  input  logic                          i_edit_dn,
  output logic [NUM_STAGES*STAGE_W-1:0] o_count,
  output logic                          o_tick,
  output logic                          o_wrap,
  output logic                          o_expired
);

  localparam int DIV = CLK_HZ / TICK_HZ;

  logic                  edit_act;
  logic                  step_tick;
  logic                  hold;
  logic                  wrap_nxt;
  logic [NUM_STAGES:0]   carry;
  logic [NUM_STAGES-1:0] at_carry;
  logic [NUM_STAGES-1:0] is_zero;

  assign edit_act  = (i_edit_up ^ i_edit_dn) && (int'(i_edit_sel) < NUM_STAGES);
  assign step_tick = o_tick & ~i_clear & ~i_load & ~edit_act;
  // One-shot countdown parks at all-zero instead of wrapping.
  assign hold      = i_dir & i_oneshot & (&is_zero);
  assign wrap_nxt  = step_tick & ~hold & carry[NUM_STAGES];
  assign carry[0]  = 1'b1;

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .run     (i_run & ~o_expired),
    .restart (i_clear | i_load),
    .tick    (o_tick)
  );

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int FIELD = int'(MODULI[k*STAGE_W +: STAGE_W]);
    localparam int MOD_K = (FIELD == 0) ? (1 << STAGE_W) : FIELD;

    mod_stage #(
      .STAGE_W  (STAGE_W),
      .MOD      (MOD_K),
      .INIT_VAL (int'(INIT[k*STAGE_W +: STAGE_W]))
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .clear    (i_clear),
      .load     (i_load),
      .load_val (i_load_val[k*STAGE_W +: STAGE_W]),
      .step     (step_tick & carry[k] & ~hold),
      .dir      (i_dir),
      .edit_up  (edit_act & i_edit_up & (int'(i_edit_sel) == k)),
      .edit_dn  (edit_act & i_edit_dn & (int'(i_edit_sel) == k)),
      .q        (o_count[k*STAGE_W +: STAGE_W]),
      .at_carry (at_carry[k])
    );

    assign carry[k+1] = carry[k] & at_carry[k];
    assign is_zero[k] = (o_count[k*STAGE_W +: STAGE_W] == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_wrap    <= 1'b0;
      o_expired <= 1'b0;
    end else begin
      o_wrap <= wrap_nxt;
      if (i_clear || i_load) begin
        o_expired <= 1'b0;
      end else if (step_tick && hold) begin
        o_expired <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cascaded_time_counter.sv
// tb/tb_cascaded_time_counter.sv - scoreboard bench for cascaded_time_counter (DIV=10, watch moduli)
module tb_cascaded_time_counter;
  import timekeep_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_run, i_clear, i_dir, i_oneshot, i_load;
  logic [27:0] i_load_val;
  logic [1:0]  i_edit_sel;
  logic        i_edit_up, i_edit_dn;
  logic [27:0] o_count;
  logic        o_tick, o_wrap, o_expired;

  always #5 clk = ~clk;

  cascaded_time_counter #(
    .CLK_HZ  (1000),
    .TICK_HZ (100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_run      (i_run),
    .i_clear    (i_clear),
    .i_dir      (i_dir),
    .i_oneshot  (i_oneshot),
    .i_load     (i_load),
    .i_load_val (i_load_val),
    .i_edit_sel (i_edit_sel),
    .i_edit_up  (i_edit_up),
    .i_edit_dn  (i_edit_dn),
    .o_count    (o_count),
    .o_tick     (o_tick),
    .o_wrap     (o_wrap),
    .o_expired  (o_expired)
  );

  typedef struct {
    string       name;
    logic [27:0] count;
    logic        tick;
    logic        wrap;
    logic        expired;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_tick = -1;
  logic gap_en   = 1'b0;

  function automatic logic [27:0] pk(int s3, int s2, int s1, int s0);
    return {7'(s3), 7'(s2), 7'(s1), 7'(s0)};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: one expected snapshot consumed per falling edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (o_count !== e.count || o_tick !== e.tick || o_wrap !== e.wrap || o_expired !== e.expired) begin
        failures++;
        $display("FAIL %s actual count=%h tick=%b wrap=%b expired=%b required count=%h tick=%b wrap=%b expired=%b",
                 e.name, o_count, o_tick, o_wrap, o_expired, e.count, e.tick, e.wrap, e.expired);
      end
    end
  end

  // Tick spacing monitor.
  always @(negedge clk) begin
    if (o_tick === 1'b1) begin
      if (gap_en && last_tick >= 0) begin
        checks++;
        if (cyc - last_tick != 10) begin
          failures++;
          $display("FAIL tick_gap actual=%0d required=10", cyc - last_tick);
        end
      end
      last_tick = cyc;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic exp_state(string n, logic [27:0] c, logic t, logic w, logic x);
    exp_t e;
    e.name = n; e.count = c; e.tick = t; e.wrap = w; e.expired = x;
    sb.push_back(e);
    @(negedge clk); #1;
  endtask

  task automatic cyc_step();
    @(posedge clk); #1;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      cyc_step();
      n++;
    end while (o_tick !== 1'b1 && n < 40);
  endtask

  task automatic pulse_load(logic [27:0] v);
    i_load_val = v; i_load = 1'b1;
    cyc_step();
    i_load = 1'b0;
  endtask

  task automatic pulse_clear();
    i_clear = 1'b1;
    cyc_step();
    i_clear = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, seen;
    reset = 1'b1; i_run = 0; i_clear = 0; i_dir = 0; i_oneshot = 0; i_load = 0;
    i_load_val = '0; i_edit_sel = SEL_HSEC; i_edit_up = 0; i_edit_dn = 0;
    repeat (3) cyc_step();
    exp_state("reset_held", pk(0,0,0,0), 0, 0, 0);
    cyc_step();
    reset = 1'b0;
    exp_state("reset_released", pk(0,0,0,0), 0, 0, 0);

    // 100 running cycles: ten ticks, stage0 reaches 10.
    last_tick = -1; gap_en = 1'b1; i_run = 1'b1;
    repeat (100) cyc_step();
    i_run = 1'b0;
    cyc_step();
    gap_en = 1'b0;
    exp_state("run_100", pk(0,0,0,10), 0, 0, 0);

    // Whole-chain wrap counting up.
    pulse_load(pk(23,59,59,99));
    exp_state("load_max", pk(23,59,59,99), 0, 0, 0);
    i_run = 1'b1;
    wait_tick(n);
    chk("load_tick_latency", n, 10);
    i_run = 1'b0;
    cyc_step();
    exp_state("up_wrap", pk(0,0,0,0), 0, 1, 0);
    cyc_step();
    exp_state("up_wrap_done", pk(0,0,0,0), 0, 0, 0);

    // One-shot countdown from one second.
    i_dir = 1'b1; i_oneshot = 1'b1;
    pulse_load(pk(0,0,1,0));
    i_run = 1'b1;
    wait_tick(n);
    cyc_step();
    exp_state("down_first", pk(0,0,0,99), 0, 0, 0);
    seen = 0;
    for (int i = 0; i < 99; i++) begin
      wait_tick(n);
      if (o_tick === 1'b1) seen++;
      cyc_step();
    end
    chk("down_ticks", seen, 99);
    exp_state("down_zero", pk(0,0,0,0), 0, 0, 0);
    wait_tick(n);
    chk("expiry_tick_seen", o_tick, 1);
    cyc_step();
    exp_state("expired", pk(0,0,0,0), 0, 0, 1);
    seen = 0;
    repeat (30) begin
      cyc_step();
      if (o_tick === 1'b1) seen++;
    end
    chk("frozen_ticks", seen, 0);
    exp_state("expired_hold", pk(0,0,0,0), 0, 0, 1);
    i_run = 1'b0;
    pulse_clear();
    exp_state("clear_expired", pk(0,0,0,0), 0, 0, 0);

    // Edit coincident with tick: edit wins, no carry, tick dropped.
    i_dir = 1'b0; i_oneshot = 1'b0;
    pulse_load(pk(0,5,59,7));
    i_run = 1'b1;
    wait_tick(n);
    chk("edit_tick_seen", o_tick, 1);
    i_edit_sel = SEL_SEC; i_edit_up = 1'b1;
    cyc_step();
    i_edit_up = 1'b0; i_run = 1'b0;
    exp_state("edit_up_wrap", pk(0,5,0,7), 0, 0, 0);
    i_edit_sel = SEL_MIN; i_edit_up = 1'b1; i_edit_dn = 1'b1;
    cyc_step();
    i_edit_up = 1'b0; i_edit_dn = 1'b0;
    exp_state("edit_both_ignored", pk(0,5,0,7), 0, 0, 0);
    i_edit_sel = SEL_HOUR; i_edit_dn = 1'b1;
    cyc_step();
    i_edit_dn = 1'b0;
    exp_state("edit_dn_wrap", pk(23,5,0,7), 0, 0, 0);

    // Saturating load, then clear.
    pulse_load(pk(30,70,5,120));
    exp_state("load_saturate", pk(23,59,5,99), 0, 0, 0);
    pulse_clear();
    exp_state("clear_init", pk(0,0,0,0), 0, 0, 0);

    // Free-running countdown wraps from all-zero to all-max.
    i_dir = 1'b1; i_run = 1'b1;
    wait_tick(n);
    chk("down_wrap_latency", n, 10);
    i_run = 1'b0;
    cyc_step();
    exp_state("down_wrap", pk(23,59,59,99), 0, 1, 0);

    // Reset at prescaler phase 7.
    i_dir = 1'b0;
    pulse_load(pk(1,2,3,4));
    i_run = 1'b1;
    repeat (7) cyc_step();
    reset = 1'b1;
    #1;
    exp_state("mid_reset", pk(0,0,0,0), 0, 0, 0);
    repeat (2) cyc_step();
    reset = 1'b0;
    wait_tick(n);
    chk("post_reset_tick_latency", n, 10);
    i_run = 1'b0;
    cyc_step();
    exp_state("post_reset_step", pk(0,0,0,1), 0, 0, 0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
